// File: rtl/systolic_sequencer.sv
// Holds the NxN A/B operand buffers and runs one CLEAR/FEED/DRAIN/DONE sequence.
// The sequence streams diagonally skewed operands into systolic_array.
module systolic_sequencer #(
    parameter int MATRIX_SIZE  = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   wr_en,
    input  logic                                   wr_sel,
    input  logic [$clog2(MATRIX_SIZE)-1:0]         wr_row,
    input  logic [$clog2(MATRIX_SIZE)-1:0]         wr_col,
    input  logic [DATA_WIDTH-1:0]                  wr_data,
    input  logic                                   start,
    input  logic                                   abort,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   acc_rst,
    output logic                                   acc_en,
    output logic                                   shift_en,
    output logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0] a_out,
    output logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0] b_out
);
    localparam int IW       = $clog2(MATRIX_SIZE);
    localparam int FEED_LEN = 2 * MATRIX_SIZE - 1;
    localparam int SW       = $clog2(FEED_LEN + DRAIN_CYCLES) + 1;
    localparam int OW       = SW + 1;

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    state_t                                 state, state_nx;
    logic [SW-1:0]                          step, step_nx;
    logic [DATA_WIDTH-1:0]                  buf_a [MATRIX_SIZE][MATRIX_SIZE];
    logic [DATA_WIDTH-1:0]                  buf_b [MATRIX_SIZE][MATRIX_SIZE];
    logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0] a_nx, b_nx;
    logic                                   running;

    assign running = (state == CLEAR) || (state == FEED) || (state == DRAIN);

    // Operand buffers have no reset so their contents survive a reset.
    always_ff @(posedge clk) begin
        if (wr_en && state == IDLE) begin
            if (wr_sel) buf_b[wr_row][wr_col] <= wr_data;
            else        buf_a[wr_row][wr_col] <= wr_data;
        end
    end

    always_comb begin
        state_nx = state;
        step_nx  = step;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = CLEAR;
                    step_nx  = '0;
                end
            end
            CLEAR: begin
                state_nx = FEED;
                step_nx  = '0;
            end
            FEED: begin
                if (step == SW'(FEED_LEN - 1)) begin
                    step_nx  = '0;
                    state_nx = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
                end else begin
                    step_nx = step + SW'(1);
                end
            end
            DRAIN: begin
                if (step == SW'(DRAIN_CYCLES - 1)) begin
                    step_nx  = '0;
                    state_nx = DONE;
                end else begin
                    step_nx = step + SW'(1);
                end
            end
            DONE:    state_nx = IDLE;
            default: begin
                state_nx = IDLE;
                step_nx  = '0;
            end
        endcase
        if (abort && running) begin
            state_nx = IDLE;
            step_nx  = '0;
        end
    end

    // Lane g carries element (step - g) of its row/column; outside 0..N-1 it is idle.
    for (genvar g = 0; g < MATRIX_SIZE; g++) begin : g_lane
        localparam logic [IW-1:0] LANE = IW'(g);
        logic [OW-1:0] off;
        logic          live;
        assign off     = {1'b0, step_nx} - OW'(g);
        assign live    = (state_nx == FEED) && ({1'b0, step_nx} >= OW'(g))
                         && (off < OW'(MATRIX_SIZE));
        assign a_nx[g] = live ? buf_a[LANE][off[IW-1:0]] : '0;
        assign b_nx[g] = live ? buf_b[off[IW-1:0]][LANE] : '0;
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            step     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            acc_rst  <= 1'b0;
            acc_en   <= 1'b0;
            shift_en <= 1'b0;
            a_out    <= '0;
            b_out    <= '0;
        end else begin
            state    <= state_nx;
            step     <= step_nx;
            busy     <= (state_nx != IDLE);
            done     <= (state_nx == DONE);
            acc_rst  <= (state_nx == CLEAR);
            acc_en   <= (state_nx == FEED) || (state_nx == DRAIN);
            shift_en <= (state_nx == FEED) || (state_nx == DRAIN);
            a_out    <= a_nx;
            b_out    <= b_nx;
        end
    end
endmodule

// File: tb/tb_systolic_sequencer.sv
// Scoreboard bench for systolic_sequencer: a matrix-level model queues the expected
// per-cycle outputs of every accepted op, and a monitor checks them plus the ideal array product.
`timescale 1ns/1ps
module tb_systolic_sequencer;
    localparam int N     = 4;
    localparam int W     = 8;
    localparam int D     = 4;
    localparam int RW    = $clog2(N);
    localparam int OPLEN = 2 * N + D + 1;

    typedef logic [511:0] wide_t;
    typedef logic [N-1:0][W-1:0] vec_t;
    typedef logic [N-1:0][N-1:0][31:0] mat_t;
    typedef struct {
        logic done;
        logic acc_rst;
        logic acc_en;
        vec_t a;
        vec_t b;
        mat_t c;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic          wr_sel = 1'b0;
    logic [RW-1:0] wr_row = '0;
    logic [RW-1:0] wr_col = '0;
    logic [W-1:0]  wr_data = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy, done, acc_rst, acc_en, shift_en;
    vec_t          a_out, b_out;

    systolic_sequencer #(.MATRIX_SIZE(N), .DATA_WIDTH(W), .DRAIN_CYCLES(D)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
        .wr_col(wr_col), .wr_data(wr_data), .start(start), .abort(abort), .busy(busy),
        .done(done), .acc_rst(acc_rst), .acc_en(acc_en), .shift_en(shift_en),
        .a_out(a_out), .b_out(b_out)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    vec_t ah[$];
    vec_t bh[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   left = 0;
    int   n_rstp = 0;
    int   n_done = 0;
    int   ma[N][N];
    int   mb[N][N];
    mat_t last_c = '0;
    exp_t mon_e;

    function automatic void check(string name, wide_t act, wide_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Expected trace of one op, built from the matrices as they stand when start is accepted.
    task automatic push_op();
        exp_t e;
        int   s;
        e = '{default: '0};
        e.acc_rst = 1'b1;
        q.push_back(e);
        for (int t = 0; t < 2 * N - 1; t++) begin
            e = '{default: '0};
            e.acc_en = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (t - i >= 0 && t - i < N) begin
                    e.a[i] = W'(ma[i][t - i]);
                    e.b[i] = W'(mb[t - i][i]);
                end
            end
            q.push_back(e);
        end
        for (int d = 0; d < D; d++) begin
            e = '{default: '0};
            e.acc_en = 1'b1;
            q.push_back(e);
        end
        e = '{default: '0};
        e.done = 1'b1;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < N; k++) s += ma[i][k] * mb[k][j];
                e.c[i][j] = 32'(s);
            end
        q.push_back(e);
        left = OPLEN;
    endtask

    task automatic tick();
        @(posedge clk);
        if (left == 0) begin
            if (rst_n && wr_en) begin
                if (wr_sel) mb[wr_row][wr_col] = int'(wr_data);
                else        ma[wr_row][wr_col] = int'(wr_data);
            end
            if (rst_n && start) push_op();
        end else if (abort && left > 1) begin
            q.delete();
            left = 0;
        end else begin
            left--;
        end
        #1;
    endtask

    task automatic write(logic sel, int r, int c, int v);
        wr_en = 1'b1; wr_sel = sel; wr_row = RW'(r); wr_col = RW'(c); wr_data = W'(v);
        tick();
        wr_en = 1'b0;
    endtask

    // abort_at: op cycle index (0 = CLEAR) that sees abort; -2 raises abort together with start.
    task automatic run_op(int abort_at, int wr_at);
        abort = (abort_at == -2);
        start = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0; wr_en = 1'b0;
        for (int c = 0; c < OPLEN + 2; c++) begin
            abort   = (c == abort_at);
            wr_en   = (c == wr_at);
            wr_sel  = 1'b0; wr_row = RW'(1); wr_col = RW'(2); wr_data = W'(9);
            tick();
        end
        abort = 1'b0; wr_en = 1'b0;
    endtask

    always @(negedge clk) begin
        mat_t cc;
        int   s;
        if (acc_rst) begin
            ah.delete();
            bh.delete();
            n_rstp++;
        end
        if (acc_en) begin
            ah.push_back(a_out);
            bh.push_back(b_out);
        end
        if (busy) begin
            if (q.size() == 0) begin
                check("unexpected_busy", wide_t'(busy), wide_t'(0));
            end else begin
                mon_e = q.pop_front();
                check("done", wide_t'(done), wide_t'(mon_e.done));
                check("acc_rst", wide_t'(acc_rst), wide_t'(mon_e.acc_rst));
                check("acc_en", wide_t'(acc_en), wide_t'(mon_e.acc_en));
                check("shift_en", wide_t'(shift_en), wide_t'(mon_e.acc_en));
                check("a_out", wide_t'(a_out), wide_t'(mon_e.a));
                check("b_out", wide_t'(b_out), wide_t'(mon_e.b));
                if (done) begin
                    for (int i = 0; i < N; i++)
                        for (int j = 0; j < N; j++) begin
                            s = 0;
                            for (int c = 0; c < ah.size() + N; c++)
                                if (c - j >= 0 && c - j < ah.size() && c - i >= 0 && c - i < bh.size())
                                    s += int'(ah[c - j][i]) * int'(bh[c - i][j]);
                            cc[i][j] = 32'(s);
                        end
                    last_c = cc;
                    n_done++;
                    check("array_result", wide_t'(cc), wide_t'(mon_e.c));
                end
            end
        end else if (q.size() != 0) begin
            check("missing_op_busy", wide_t'(busy), wide_t'(1));
            q.delete();
        end else begin
            check("idle_outputs", wide_t'({done, acc_rst, acc_en, shift_en, a_out, b_out}), wide_t'(0));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0;
        rst_n = 1'b0;
        repeat (2) tick();
        check("reset_outputs", wide_t'({busy, done, acc_rst, acc_en, shift_en, a_out, b_out}), wide_t'(0));
        rst_n = 1'b1;
        tick();

        // A = identity, B = 1..16 row-major: result must equal B.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                write(1'b0, i, j, (i == j) ? 1 : 0);
                write(1'b1, i, j, i * N + j + 1);
            end
        run_op(-1, -1);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                check("identity_c", wide_t'(last_c[i][j]), wide_t'(i * N + j + 1));

        // A = 1..16 with the last write in the start cycle; a write during the op is dropped.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (!(i == N - 1 && j == N - 1)) write(1'b0, i, j, i * N + j + 1);
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = RW'(N - 1); wr_col = RW'(N - 1); wr_data = W'(16);
        run_op(-1, 4);
        check("c00", wide_t'(last_c[0][0]), wide_t'(90));
        check("c33", wide_t'(last_c[3][3]), wide_t'(600));
        check("c12", wide_t'(last_c[1][2]), wide_t'(5 * 3 + 6 * 7 + 7 * 11 + 8 * 15));

        // Asynchronous reset at FEED step 3, then a fresh run from the retained buffers.
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        q.delete();
        left = 0;
        #1;
        check("async_reset_outputs", wide_t'({busy, done, acc_rst, acc_en, shift_en, a_out, b_out}), wide_t'(0));
        tick();
        rst_n = 1'b1;
        tick();
        run_op(-1, -1);

        // Abort at DRAIN cycle 1: no done; a following op completes.
        d0 = n_done;
        run_op(9, -1);
        check("abort_no_done", wide_t'(n_done), wide_t'(d0));
        run_op(-1, -1);
        check("after_abort_done", wide_t'(n_done), wide_t'(d0 + 1));
        run_op(OPLEN - 1, -1);
        check("abort_in_done", wide_t'(n_done), wide_t'(d0 + 2));
        run_op(-2, -1);
        check("start_beats_abort", wide_t'(n_done), wide_t'(d0 + 3));

        // start held high for 20 cycles: two back-to-back ops.
        d0 = n_done;
        r0 = n_rstp;
        start = 1'b1;
        repeat (20) tick();
        start = 1'b0;
        repeat (20) tick();
        check("held_start_ops", wide_t'(n_done), wide_t'(d0 + 2));
        check("held_start_acc_rst", wide_t'(n_rstp), wide_t'(r0 + 2));

        // Random operands, writes, starts and aborts.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                write(1'b0, i, j, int'($urandom_range(0, 255)));
                write(1'b1, i, j, int'($urandom_range(0, 255)));
            end
        for (int n = 0; n < 600; n++) begin
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_sel  = ($urandom_range(0, 1) == 1);
            wr_row  = RW'($urandom_range(0, N - 1));
            wr_col  = RW'($urandom_range(0, N - 1));
            wr_data = W'($urandom_range(0, 255));
            start   = ($urandom_range(0, 5) == 0);
            abort   = ($urandom_range(0, 29) == 0);
            tick();
        end
        wr_en = 1'b0; start = 1'b0; abort = 1'b0;
        repeat (OPLEN + 4) tick();
        check("scoreboard_drained", wide_t'(q.size()), wide_t'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
